// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer feeding the first radix-2 DIT butterfly stage.
// Samples arrive in natural order. Each N-point frame is emitted as
// bit-reversed pairs whose two addresses differ by N/2.
module fft_bitrev_buf #(
    parameter int N_LOG2 = 3,
    parameter int WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    s_valid,
    input  logic signed [WIDTH-1:0] s_re,
    input  logic signed [WIDTH-1:0] s_im,
    output logic                    s_ready,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] x1,
    output logic signed [WIDTH-1:0] img1,
    output logic signed [WIDTH-1:0] x2,
    output logic signed [WIDTH-1:0] img2,
    output logic                    m_last
);

    localparam int N = 1 << N_LOG2;
    localparam int P = N_LOG2 - 1;

    logic signed [WIDTH-1:0] mem_re [2][N];
    logic signed [WIDTH-1:0] mem_im [2][N];

    logic [1:0]        bank_full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wbank;
    logic              rbank;
    logic [N_LOG2-1:0] wcnt;
    logic [P-1:0]      rcnt;
    logic [N_LOG2-1:0] addr1;
    logic [N_LOG2-1:0] addr2;

    logic accept;
    logic w_last;
    logic load;
    logic rd_last;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
        return {<<{a}};
    endfunction

    assign s_ready = ce & ~bank_full[wbank];
    assign accept  = s_valid & s_ready;
    assign w_last  = &wcnt;
    assign load    = ce & bank_full[rbank] & (~m_valid | m_ready);
    assign rd_last = &rcnt;
    assign addr1   = bitrev({rcnt, 1'b0});
    assign addr2   = bitrev({rcnt, 1'b1});

    // Sample storage; not cleared by reset
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem_re[wbank][wcnt] <= s_re;
            mem_im[wbank][wcnt] <= s_im;
        end
    end

    // Per-bank full flag set/clear requests for this edge
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (accept && w_last) full_set[wbank] = 1'b1;
        if (load && rd_last)  full_clr[rbank] = 1'b1;
    end

    // Write/read pointers, counters and bank flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_full <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
        end else begin
            if (accept) begin
                wcnt <= wcnt + N_LOG2'(1);
                if (w_last) wbank <= ~wbank;
            end
            if (load) begin
                rcnt <= rcnt + P'(1);
                if (rd_last) rbank <= ~rbank;
            end
            bank_full <= (bank_full | full_set) & ~full_clr;
        end
    end

    // Output pair register with valid/ready hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            x1      <= '0;
            img1    <= '0;
            x2      <= '0;
            img2    <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_last  <= rd_last;
            x1      <= mem_re[rbank][addr1];
            img1    <= mem_im[rbank][addr1];
            x2      <= mem_re[rbank][addr2];
            img2    <= mem_im[rbank][addr2];
        end else if (ce && m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Directed bench for fft_bitrev_buf with N = 8, WIDTH = 16.
module tb_fft_bitrev_buf;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] x1;
        logic [W-1:0] img1;
        logic [W-1:0] x2;
        logic [W-1:0] img2;
        logic         last;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b1;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_re = '0;
    logic [W-1:0] s_im = '0;
    logic         m_ready = 1'b1;
    logic         s_ready;
    logic         m_valid;
    logic         m_last;
    logic [W-1:0] x1, img1, x2, img2;

    int tests = 0;
    int fails = 0;
    logic ce_toggle = 1'b0;
    int unsigned cyc = 0;
    pair_t q[$];
    int unsigned cyc_q[$];
    pair_t tbl[4];
    int ord[4];

    fft_bitrev_buf #(.N_LOG2(3), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .s_valid(s_valid), .s_re(s_re), .s_im(s_im), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready),
        .x1(x1), .img1(img1), .x2(x2), .img2(img2), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Record every completed output handshake
    always @(posedge clk) begin
        cyc++;
        if (rst_n && ce && m_valid && m_ready) begin
            q.push_back({x1, img1, x2, img2, m_last});
            cyc_q.push_back(cyc);
        end
    end

    // While ce is gated off, outputs must not move across the edge
    always @(posedge clk) begin
        if (ce_toggle && !ce && rst_n) begin
            logic [65:0] snap;
            snap = {m_valid, x1, img1, x2, img2, m_last};
            #1;
            chk("ce_freeze", {m_valid, x1, img1, x2, img2, m_last}, snap);
        end
    end

    task automatic tick();
        @(negedge clk);
        if (ce_toggle) ce = ~ce;
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, output int stalls);
        int n = 0;
        tick();
        s_valid = 1'b1;
        s_re = re;
        s_im = im;
        #1;
        while (!s_ready && n < 300) begin
            tick();
            #1;
            n++;
        end
        chk("send_bound", (n >= 300), 0);
        stalls = n;
        @(posedge clk);
    endtask

    task automatic idle();
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_pairs(input int n);
        int k = 0;
        while (q.size() < n && k < 400) begin
            tick();
            k++;
        end
        chk("wait_pairs", (q.size() >= n), 1);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q.delete();
        cyc_q.delete();
    endtask

    task automatic chk_pair(input string name, input int idx, input pair_t e);
        pair_t a;
        a = (idx < q.size()) ? q[idx] : '1;
        chk(name, a, e);
    endtask

    function automatic pair_t mk(input int base, input int j);
        pair_t p;
        p.x1   = W'(base + ord[j]);
        p.img1 = W'(100 + base + ord[j]);
        p.x2   = W'(base + ord[j] + 4);
        p.img2 = W'(100 + base + ord[j] + 4);
        p.last = (j == 3);
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int tot;
        int maxgap;

        ord[0] = 0; ord[1] = 2; ord[2] = 1; ord[3] = 3;
        tbl[0] = '{x1: 16'd0, img1: 16'd100, x2: 16'd4, img2: 16'd104, last: 1'b0};
        tbl[1] = '{x1: 16'd2, img1: 16'd102, x2: 16'd6, img2: 16'd106, last: 1'b0};
        tbl[2] = '{x1: 16'd1, img1: 16'd101, x2: 16'd5, img2: 16'd105, last: 1'b0};
        tbl[3] = '{x1: 16'd3, img1: 16'd103, x2: 16'd7, img2: 16'd107, last: 1'b1};

        // Single frame, reset state and latency
        do_reset();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_data", {x1, img1, x2, img2, m_last}, 0);
        for (int i = 0; i < 8; i++) send(W'(i), W'(100 + i), st);
        tick();
        s_valid = 1'b0;
        chk("lat_after_T", m_valid, 0);
        tick();
        chk("lat_after_T1", {m_valid, x1, x2}, {1'b1, 16'd0, 16'd4});
        wait_pairs(4);
        for (int j = 0; j < 4; j++) chk_pair("single_pair", j, tbl[j]);

        // Back-to-back frames
        do_reset();
        tot = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 8; i++) begin
                send(W'(f * 10 + i), W'(100 + f * 10 + i), st);
                tot += st;
            end
        idle();
        chk("b2b_stalls", tot, 0);
        wait_pairs(16);
        for (int f = 0; f < 4; f++)
            for (int j = 0; j < 4; j++) chk_pair("b2b_pair", f * 4 + j, mk(f * 10, j));
        maxgap = 0;
        for (int k = 1; k < cyc_q.size(); k++)
            if (int'(cyc_q[k] - cyc_q[k-1]) > maxgap) maxgap = int'(cyc_q[k] - cyc_q[k-1]);
        chk("b2b_gap", (maxgap <= 5), 1);

        // Backpressure with both banks filling
        do_reset();
        m_ready = 1'b0;
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            send(W'(i), W'(100 + i), st);
            tot += st;
        end
        chk("bp_fill_stalls", tot, 0);
        tick();
        s_valid = 1'b1;
        s_re = 16'd16;
        s_im = 16'd116;
        #1;
        chk("bp_sready_low", s_ready, 0);
        chk("bp_first", {m_valid, x1, img1, x2, img2}, {1'b1, 16'd0, 16'd100, 16'd4, 16'd104});
        repeat (5) tick();
        chk("bp_hold", {m_valid, x1, img1, x2, img2, s_ready},
            {1'b1, 16'd0, 16'd100, 16'd4, 16'd104, 1'b0});
        m_ready = 1'b1;
        send(16'd16, 16'd116, st);
        chk("bp_sready_waits", (st > 0), 1);
        for (int i = 17; i < 20; i++) send(W'(i), W'(100 + i), st);
        idle();
        wait_pairs(8);
        repeat (10) tick();
        chk("bp_count", q.size(), 8);
        for (int f = 0; f < 2; f++)
            for (int j = 0; j < 4; j++) chk_pair("bp_pair", f * 4 + j, mk(f * 8, j));

        // Reset mid-frame with a pending output frame
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(W'(20 + i), W'(120 + i), st);
        for (int i = 0; i < 5; i++) send(W'(30 + i), W'(130 + i), st);
        tick();
        s_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out", {m_valid, m_last, x1, img1, x2, img2, s_ready}, {2'b00, 64'd0, 1'b1});
        m_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) send(W'(50 + i), W'(150 + i), st);
        idle();
        wait_pairs(4);
        for (int j = 0; j < 4; j++) chk_pair("mid_rst_pair", j, mk(50, j));

        // Clock-enable gating
        do_reset();
        ce_toggle = 1'b1;
        for (int i = 0; i < 8; i++) send(W'(i), W'(100 + i), st);
        idle();
        wait_pairs(4);
        repeat (6) tick();
        ce_toggle = 1'b0;
        ce = 1'b1;
        chk("ce_count", q.size(), 4);
        for (int j = 0; j < 4; j++) chk_pair("ce_pair", j, tbl[j]);

        // Signed extremes pass through unchanged
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      send(16'h8000, 16'h7FFF, st);
            else if (i == 4) send(16'h7FFF, 16'h8000, st);
            else             send(W'(i), W'(i), st);
        end
        idle();
        wait_pairs(1);
        chk_pair("extreme_pair", 0, '{x1: 16'h8000, img1: 16'h7FFF, x2: 16'h7FFF, img2: 16'h8000, last: 1'b0});

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
